// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/busy/done handshake and Hi/Lo result bus of the multiply/divide unit
// master (control unit) drives start, op, a, b; slave (muldiv_unit) drives busy, done, div_zero, hi, lo
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide engine that owns the Hi/Lo registers
// clk: rising-edge clock; reset: asynchronous active-low
// bus.start/op/a/b: request (op 00 mult, 01 div, 10 multu, 11 divu); bus.busy/done/div_zero: status
// bus.hi/lo: product halves, or remainder/quotient
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic reset,
  muldiv_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, DZ} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_res, neg_dvd, busy, done, div_zero, sgn;
  logic [WIDTH-1:0]   mag_b, hi, lo, ma, mb;
  logic [2*WIDTH-1:0] acc, mul_next, div_next, prod;
  logic [WIDTH:0]     trial, msum;
  assign sgn = ~bus.op[1];
  assign ma = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mb = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  // multiply: add the multiplicand into the upper half when the low bit is set, then shift right
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign mul_next = {msum, acc[WIDTH-1:1]};
  // divide: upper half is the partial remainder, lower half shifts the dividend out and quotient bits in
  assign trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mag_b};
  assign div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign prod = neg_res ? -acc : acc;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.div_zero = div_zero;
  assign bus.hi = hi;
  assign bus.lo = lo;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      neg_res <= 1'b0;
      neg_dvd <= 1'b0;
      mag_b <= '0;
      acc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo <= neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi <= neg_dvd ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else
            {hi, lo} <= prod;
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
          if (bus.start) begin
            acc <= {{WIDTH{1'b0}}, ma};
            mag_b <= mb;
            is_div <= bus.op[0];
            neg_res <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_dvd <= sgn & bus.a[WIDTH-1];
            cnt <= '0;
            if (bus.op[0] && bus.b == '0) begin
              state <= DZ;
              done <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy <= 1'b1;
            end
          end
        end
      endcase
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  typedef struct {
    string       nm;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (reset && bus.done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h dz=%b with nothing queued", bus.hi, bus.lo, bus.div_zero);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk(e.nm, {bus.div_zero, bus.hi, bus.lo}, {e.dz, e.hi, e.lo});
      end
    end
  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz, input int lat, input bit glitch);
    int n, bn;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    q.push_back('{nm, edz, eh, el});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = ~o;
    bus.a = ~x;
    bus.b = 32'd0;
    n = 0;
    bn = 0;
    while (n < 100) begin
      @(negedge clk);
      if (glitch) begin
        bus.start = (n == 5);
        bus.op = 2'b01;
        bus.b = 32'd0;
      end
      if (bus.done) break;
      if (bus.busy) bn++;
      n++;
    end
    bus.start = 1'b0;
    chk({nm, "_latency"}, 65'(n), 65'(lat));
    chk({nm, "_busy_cycles"}, 65'(bn), 65'(lat));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = 32'd0;
    bus.b = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo}, 65'd0);
    reset = 1'b1;
    do_op("mult_7xm3", 2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b0);
    do_op("multu_max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b0);
    do_op("mult_m1xm1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 33, 1'b0);
    do_op("div_m7d2", 2'b01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
    do_op("div_7dm2", 2'b01, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
    do_op("divu_big", 2'b11, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, 1'b0, 33, 1'b0);
    do_op("div_ovf", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, 1'b0);
    do_op("divu_preload", 2'b11, 32'h3412, 32'h100, 32'h12, 32'h34, 1'b0, 33, 1'b0);
    do_op("div_zero", 2'b01, 32'd5, 32'd0, 32'h12, 32'h34, 1'b1, 0, 1'b0);
    do_op("mult_ignored_start", 2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b1);
    repeat (3) @(negedge clk);
    chk("queue_empty", 65'(q.size()), 65'd0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b10;
    bus.a = 32'd9;
    bus.b = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_reset", {bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo}, 65'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", {bus.busy, bus.hi, bus.lo}, 65'd0);
    do_op("mult_3x5", 2'b00, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 33, 1'b0);
    repeat (2) @(negedge clk);
    chk("final_queue_empty", 65'(q.size()), 65'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
